mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one external single-port memory between instruction fetch (IF) and data access (DM).
//  Sits between the fetch stage / memory stage and the memory bus.
//  Runs one transaction at a time with a req/gnt/rvalid handshake per requester.
//  Requesters use o_*_gnt and o_*_rvalid to build stall_f / stall_m.
// PARAMETERS
//  P_DATA_WIDTH  32  data bus width; must be a multiple of 8
//  P_ADDR_WIDTH  10  byte address width
// PORTS
//  i_clk         in   1             clock, rising edge
//  i_rst         in   1             synchronous reset, active-high
//  i_if_req      in   1             fetch request; held until o_if_gnt
//  i_if_addr     in   P_ADDR_WIDTH  fetch address
//  i_if_flush    in   1             discard in-flight fetch response (branch taken)
//  o_if_gnt      out  1             fetch request accepted this cycle
//  o_if_rvalid   out  1             fetch data valid
//  o_if_rdata    out  P_DATA_WIDTH  fetch data
//  i_dm_req      in   1             data request; held until o_dm_gnt
//  i_dm_we       in   1             1 = write, 0 = read
//  i_dm_addr     in   P_ADDR_WIDTH  data address
//  i_dm_wdata    in   P_DATA_WIDTH  write data
//  i_dm_be       in   P_DATA_WIDTH/8  byte enables
//  o_dm_gnt      out  1             data request accepted this cycle
//  o_dm_rvalid   out  1             data read valid or write complete
//  o_dm_rdata    out  P_DATA_WIDTH  read data; 0 on write completion
//  o_mem_req     out  1             memory request; held until i_mem_ready
//  o_mem_we      out  1             memory write enable
//  o_mem_addr    out  P_ADDR_WIDTH  memory address
//  o_mem_wdata   out  P_DATA_WIDTH  memory write data
//  o_mem_be      out  P_DATA_WIDTH/8  memory byte enables
//  i_mem_ready   in   1             memory accepts request
//  i_mem_rvalid  in   1             memory read data valid
//  i_mem_rdata   in   P_DATA_WIDTH  memory read data
//  o_busy        out  1             state != IDLE
// BEHAVIOUR
//  - FSM states:
//      IDLE: grant.
//      REQ: o_mem_req=1, waiting for i_mem_ready.
//      RESP: read in flight, waiting for i_mem_rvalid.
//  - IDLE, any req: grant is combinational.
//      Exactly one o_*_gnt pulses.
//      The winner's command is captured into the o_mem_* registers.
//      Next state is REQ.
//  - REQ & i_mem_ready & read: next state is RESP.
//  - REQ & i_mem_ready & write: o_dm_rvalid=1 in the next cycle (rdata=0), then IDLE.
//  - REQ & !i_mem_ready: o_mem_* stay stable.
//  - RESP & i_mem_rvalid: o_<owner>_rvalid=1 the same cycle; rdata passes through. Next state is IDLE.
//  - Read latency with zero-wait memory:
//      gnt at cycle N, o_mem_req at N+1, rvalid earliest N+2.
//      Next gnt at N+3.
//  - Priority (default): DM wins over IF when both request in IDLE.
//  - Only the owner's rvalid may assert; the other rvalid stays 0.
//  - i_if_flush during REQ/RESP of a fetch:
//      Sets a drop flag.
//      The memory transaction still completes.
//      o_if_rvalid is suppressed for it.
//      The flag clears on return to IDLE.
//  - i_if_flush in the same cycle as o_if_rvalid suppresses that rvalid.
//  - i_if_flush has no effect on DM transactions.
//  - i_mem_rvalid outside RESP is ignored.
//  - Request deasserted before gnt: legal; nothing is issued.
//  - Reset (also mid-transaction):
//      State goes to IDLE.
//      All outputs are 0, including o_mem_*, gnt, rvalid, rdata and o_busy.
//      The drop flag is cleared and any pending response is discarded.
//  - Addresses pass unmodified; no alignment check.
// CONFIGURATION
//  ARB_RR_EN undefined: fixed priority, DM over IF.
//  ARB_RR_EN defined: round-robin.
//  - A 1-bit last-owner register is updated on each gnt.
//  - On contention, the requester that was not last granted wins.
//  - Reset value of last-owner is IF, so DM wins the first contention.
//  Single requester behaviour is identical in both modes.
// TESTING
//  1. IF read at 0x004, ready=1, rvalid 1 cycle later with 0x00500093:
//     o_if_gnt at N, o_mem_req at N+1, o_if_rvalid with 0x00500093 at N+2, o_busy 0 at N+3.
//  2. IF and DM read requested together in IDLE (default build):
//     o_dm_gnt first. o_if_gnt in the first IDLE cycle after the DM rvalid.
//  3. Same stimulus held for 4 transactions with ARB_RR_EN defined:
//     grants in order DM, IF, DM, IF.
//  4. DM write to 0x010, data 0xDEADBEEF, be=4'b0011, ready delayed 3 cycles:
//     o_mem_* stable for 3 cycles; o_dm_rvalid=1 with rdata=0 in the cycle after ready.
//  5. i_if_flush pulsed in RESP of a fetch:
//     no o_if_rvalid; state returns to IDLE on i_mem_rvalid; the next fetch returns data normally.
//  6. i_rst asserted in RESP, with i_mem_rvalid arriving during reset:
//     all outputs 0, no rvalid, o_busy=0; IF gnt in the first cycle after reset release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and data access (DM), one transaction at a time.
// Optional build macro ARB_RR_EN: round-robin arbitration on contention.
// Without ARB_RR_EN, DM has fixed priority over IF.
module mem_port_arbiter #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_if_req,
  input  logic [P_ADDR_WIDTH-1:0]   i_if_addr,
  input  logic                      i_if_flush,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic [P_DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                      i_dm_req,
  input  logic                      i_dm_we,
  input  logic [P_ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [P_DATA_WIDTH-1:0]   i_dm_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] i_dm_be,
  output logic                      o_dm_gnt,
  output logic                      o_dm_rvalid,
  output logic [P_DATA_WIDTH-1:0]   o_dm_rdata,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [P_ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [P_DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                      i_mem_ready,
  input  logic                      i_mem_rvalid,
  input  logic [P_DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_reg, state_next;
  logic   owner_dm_reg;   // 1 = current transaction belongs to DM
  logic   drop_reg;       // in-flight fetch response must be discarded
  logic   wr_done_reg;    // write accepted last cycle: pulse DM completion
  logic   dm_first;       // DM wins when both request
  logic   dm_win;
  logic   if_win;
  logic   rd_done;

`ifdef ARB_RR_EN
  logic last_dm_reg;      // 1 = DM was granted most recently

  // Round-robin history: remember who got the last grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_dm_reg <= 1'b0;
    end else if (dm_win) begin
      last_dm_reg <= 1'b1;
    end else if (if_win) begin
      last_dm_reg <= 1'b0;
    end
  end

  assign dm_first = !last_dm_reg;
`else
  assign dm_first = 1'b1;
`endif

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_next  = state_reg;
    dm_win      = 1'b0;
    if_win      = 1'b0;
    rd_done     = 1'b0;
    o_dm_gnt    = 1'b0;
    o_if_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_dm_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_dm_rdata  = '0;
    if (!i_rst) begin
      case (state_reg)
        IDLE: begin
          dm_win = i_dm_req && (!i_if_req || dm_first);
          if_win = i_if_req && !dm_win;
          if (dm_win || if_win) begin
            state_next = REQ;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            state_next = o_mem_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            rd_done    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      o_dm_gnt    = dm_win;
      o_if_gnt    = if_win;
      // A flush in the very cycle the data returns also kills the response.
      o_if_rvalid = rd_done && !owner_dm_reg && !drop_reg && !i_if_flush;
      o_dm_rvalid = (rd_done && owner_dm_reg) || wr_done_reg;
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_dm_rdata  = (rd_done && owner_dm_reg) ? i_mem_rdata : '0;
    end
  end

  assign o_mem_req = (state_reg == REQ);
  assign o_busy    = (state_reg != IDLE);

  // State, owner, drop flag and the captured memory command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      owner_dm_reg <= 1'b0;
      drop_reg     <= 1'b0;
      wr_done_reg  <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_be     <= '0;
    end else begin
      state_reg   <= state_next;
      wr_done_reg <= (state_reg == REQ) && i_mem_ready && o_mem_we;
      if (dm_win) begin
        owner_dm_reg <= 1'b1;
        o_mem_we     <= i_dm_we;
        o_mem_addr   <= i_dm_addr;
        o_mem_wdata  <= i_dm_wdata;
        o_mem_be     <= i_dm_be;
      end else if (if_win) begin
        // Fetches are always full-word reads.
        owner_dm_reg <= 1'b0;
        o_mem_we     <= 1'b0;
        o_mem_addr   <= i_if_addr;
        o_mem_wdata  <= '0;
        o_mem_be     <= '1;
      end
      if (state_reg == IDLE) begin
        drop_reg <= 1'b0;
      end else if (i_if_flush && !owner_dm_reg) begin
        drop_reg <= 1'b1;
      end
    end
  end

endmodule
